// File: rtl/ram_access_ctrl.sv
// Request sequencer for the level-sensitive RAM array: buffers word requests in a
// small FIFO and drives address/data/rw with a setup/strobe/release sequence.
module ram_access_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int WAIT_CYCLES    = 2,
    parameter int NUM_CHIPS      = 8,
    parameter int WORDS_PER_CHIP = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_rw,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_rw,
    input  logic [31:0] mem_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, SETUP, ACCESS, STROBE, RELEASE, RESP
    } state_t;

    state_t state, next_state;

    logic [64:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    logic              work_rw;
    logic [31:0]       work_addr;
    logic [31:0]       work_wdata;
    logic              addr_err;

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic              load_mem, load_wait, capture;

    assign req_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign wait_last = (wait_cnt == WAIT_W'(1));

    assign addr_err = ({1'b0, work_addr[31:24]} >= 9'(NUM_CHIPS)) ||
                      ({1'b0, work_addr[23:0]}  >= 25'(WORDS_PER_CHIP));

    // NOTE: payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {req_rw, req_addr, req_wdata};
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: defaults assigned before the case so no path leaves a signal unassigned (no latches).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = DECODE;
            DECODE:  next_state = addr_err ? RESP : SETUP;
            SETUP:   next_state = work_rw ? STROBE : ACCESS;
            ACCESS:  if (wait_last) next_state = RESP;
            STROBE:  if (wait_last) next_state = RELEASE;
            RELEASE: next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop        = (state == IDLE) && (count != '0);
        load_mem   = (state == DECODE) && !addr_err;
        load_wait  = (state == SETUP);
        capture    = (state == ACCESS) && wait_last;
        mem_rw     = (state == STROBE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_rw    <= 1'b0;
            work_addr  <= '0;
            work_wdata <= '0;
        end else if (pop) begin
            {work_rw, work_addr, work_wdata} <= fifo_mem[rd_ptr];
        end
    end

    // Counter keeps running down to zero after the wait state is left; it is reloaded per access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (load_wait)
            wait_cnt <= WAIT_W'(WAIT_CYCLES);
        else if (wait_cnt != '0)
            wait_cnt <= wait_cnt - WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address <= '0;
            mem_dataIn  <= '0;
        end else if (load_mem) begin
            mem_address <= work_addr;
            mem_dataIn  <= work_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rw    <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (state == DECODE) begin
            resp_rw    <= work_rw;
            resp_err   <= addr_err;
            resp_rdata <= '0;
        end else if (capture) begin
            resp_rdata <= mem_out;
        end
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request sequencer between the CPU load/store path and the `RAM` array. It accepts word read/write requests over a valid/ready handshake and buffers them in a small FIFO. It drives `RAM`'s level-sensitive `address`/`dataIn`/`rw` inputs with a glitch-free setup/strobe/release sequence, so the array never sees `rw=1` while address or data is changing. It returns read data or an error response over a second valid/ready handshake.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries (power of 2, ≥2).
- `WAIT_CYCLES`, 2: cycles address/strobe held before read capture or write release (≥1).
- `NUM_CHIPS`, 8: valid chip selects, `address[31:24]` < `NUM_CHIPS`.
- `WORDS_PER_CHIP`, 32: valid word index range per chip.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals `!full`.
- `req_rw`  in  1  1 = write, 0 = read (same polarity as `RAM.rw`).
- `req_addr`  in  32  chip in [31:24], word index in [23:0].
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rw`  out  1  echo of request `rw`.
- `resp_err`  out  1  address out of range; no array access made.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `mem_address`  out  32  to `RAM.address`.
- `mem_dataIn`  out  32  to `RAM.dataIn`.
- `mem_rw`  out  1  to `RAM.rw`.
- `mem_out`  in  32  from `RAM.out`.

## Operation
- Request is accepted on a rising edge when `req_valid && req_ready`. Push into the FIFO is {rw, addr, wdata}.
- Simultaneous push and pop: count unchanged. Push while full cannot occur, because ready is low.
- FSM states: IDLE, DECODE, SETUP, ACCESS, STROBE, RELEASE, RESP.
- IDLE: if FIFO non-empty, pop the head into the working register, then go to DECODE.
- DECODE: error if `addr[31:24] >= NUM_CHIPS` or `addr[23:0] >= WORDS_PER_CHIP`.
  - Error: go to RESP with `resp_err=1`, `resp_rdata=0`.
  - Otherwise: go to SETUP.
- SETUP: `mem_address`/`mem_dataIn` are loaded from the working register and `mem_rw=0`, for 1 cycle. Read goes to ACCESS; write goes to STROBE.
- ACCESS: held for `WAIT_CYCLES` cycles. On the last edge, capture `mem_out` into `resp_rdata` and go to RESP.
- STROBE: `mem_rw=1` for `WAIT_CYCLES` cycles with address/data stable, then go to RELEASE.
- RELEASE: `mem_rw=0` with address/data still stable, for 1 cycle, then go to RESP.
- RESP: `resp_valid=1` with response fields stable until `resp_valid && resp_ready`. On that edge, go to IDLE.
- `mem_rw` is 1 only in STROBE.
- `mem_address`/`mem_dataIn` change only on the edge entering SETUP; otherwise they hold their last value.
- Wait counter: `$clog2(WAIT_CYCLES+1)` bits. It is loaded on the edge entering ACCESS/STROBE and decremented each cycle; the state is left when it reaches 1.

## Timing
- Reset (asynchronous, immediate) forces:
  - FSM to IDLE and FIFO empty;
  - `req_ready=1`;
  - `resp_valid`, `resp_rw`, `resp_err`, `resp_rdata`, `mem_address`, `mem_dataIn`, `mem_rw` all to 0.
- Reset during STROBE drops `mem_rw` immediately. The in-flight write may be partial and the array contents are undefined for that word. Queued requests are discarded.
- Latency from the accept edge to `resp_valid` high, with an empty FIFO and idle FSM:
  - read: `3+WAIT_CYCLES` cycles (5 by default);
  - write: `4+WAIT_CYCLES` cycles (6 by default);
  - error: 2 cycles.
- `req_ready` is combinational from the FIFO count only, never from `req_valid`.
- Responses are returned in request order; one request is in flight at a time.
- `resp_ready` low stalls the FSM in RESP. The FIFO keeps accepting until full.

## Test plan
- Write `0x0300_0005 <- 0xDEADBEEF`, then read the same address:
  - write response at 6 cycles: `resp_rw=1`, `resp_err=0`;
  - read response at 5 cycles: `resp_rdata=0xDEADBEEF`;
  - `mem_rw` high exactly 2 cycles, with `mem_address` stable from 1 cycle before to 1 cycle after.
- Read `0x0800_0000` and `0x0000_0020` → each `resp_err=1`, `resp_rdata=0`, 2-cycle latency, `mem_rw` never asserted, `mem_address` unchanged.
- Hold `resp_ready=0` and push 5 requests → `req_ready` drops after the 5th accept (4 queued plus 1 in RESP). Releasing `resp_ready` drains all 5 responses in order.
- Push a request on the same edge a pop occurs with the FIFO full-1 → count unchanged, no request lost or duplicated.
- Assert `rst` mid-STROBE → `mem_rw` and `resp_valid` go 0 before the next edge, `req_ready=1`, no response is issued for the aborted or queued requests.
- Back-to-back writes to chips 0–7 word 31, then readback → all 8 values returned correctly, and `mem_address` never changes while `mem_rw=1`.
